// File: rtl/clk_rst_gen_pkg.sv
// Shared types and helpers for the p601zero clock/reset/RTC-interrupt block.
package p601_clk_pkg;

    localparam int IRQ_MISS_W = 8;
    localparam logic [IRQ_MISS_W-1:0] IRQ_MISS_MAX = '1;

    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        COUNT = 2'd1,
        RUN   = 2'd2
    } seq_state_t;

    // Half-period of a divided clock in oscillator cycles; 0 flags an unusable ratio.
    function automatic int div_half(input int osc, input int f);
        if (f <= 0) begin
            return 0;
        end
        return (osc / f) / 2;
    endfunction

endpackage

// File: rtl/clk_rst_gen_clk_div.sv
// Toggle divider: output flips every DIV input cycles, with a registered
// rising-edge pulse and a look-ahead flag for the coming falling edge.
module clk_div #(
    parameter int DIV   = 2,
    parameter int CNT_W = 25
) (
    input  logic clk_in,
    input  logic b_reset,
    output logic clk_out,
    output logic rise,
    output logic fall_next
);

    localparam logic [CNT_W-1:0] TERM = CNT_W'(DIV - 1);

    generate
        if (DIV < 1 || longint'(DIV) > (longint'(1) << CNT_W)) begin : g_bad_div
            $error("clk_div: DIV must be in 1..2**CNT_W");
        end
    endgenerate

    logic [CNT_W-1:0] cnt_reg;
    logic             out_reg;
    logic             rise_reg;
    logic             at_term;

    assign at_term = (cnt_reg == TERM);

    always_ff @(posedge clk_in or negedge b_reset) begin
        if (!b_reset) begin
            cnt_reg  <= '0;
            out_reg  <= 1'b0;
            rise_reg <= 1'b0;
        end else if (at_term) begin
            cnt_reg  <= '0;
            out_reg  <= ~out_reg;
            rise_reg <= ~out_reg;
        end else begin
            cnt_reg  <= cnt_reg + CNT_W'(1);
            rise_reg <= 1'b0;
        end
    end

    assign clk_out   = out_reg;
    assign rise      = rise_reg;
    // High in the cycle whose closing edge drives the output 1->0.
    assign fall_next = at_term & out_reg;

endmodule

// File: rtl/clk_rst_gen.sv
// CPU/RTC clock generation, stretched CPU reset, latched RTC interrupt with
// miss counter, and 7-segment power multiplexing for the p601zero SoC.
module clk_rst_gen
    import p601_clk_pkg::*;
#(
    parameter int OSC_CLOCK  = 12000000,
    parameter int CPU_CLOCK  = 3000000,
    parameter int RTC_CLOCK  = 50,
    parameter int RES_CYCLES = 4,
    parameter int CNT_W      = 25
) (
    input  logic                  clk_in,
    input  logic                  b_reset,
    input  logic                  irq_ack,
    output logic                  sys_clk,
    output logic                  sys_clk_rise,
    output logic                  sys_res,
    output logic                  rtc_clk,
    output logic                  rtc_tick,
    output logic                  sys_irq,
    output logic [IRQ_MISS_W-1:0] irq_miss,
    output logic                  led_pow_h,
    output logic                  led_pow_l
);

    localparam int CLK_DIV = div_half(OSC_CLOCK, CPU_CLOCK);
    localparam int RTC_DIV = div_half(OSC_CLOCK, RTC_CLOCK);
    localparam int RCNT_W  = (RES_CYCLES < 1) ? 1 : $clog2(RES_CYCLES + 1);
    localparam logic [RCNT_W-1:0] RES_INIT = RCNT_W'(RES_CYCLES);

    generate
        if (RES_CYCLES < 0) begin : g_bad_res
            $error("clk_rst_gen: RES_CYCLES must not be negative");
        end
    endgenerate

    logic sys_fall_next;
    logic rtc_fall_unused;

    clk_div #(
        .DIV   (CLK_DIV),
        .CNT_W (CNT_W)
    ) u_sys_div (
        .clk_in    (clk_in),
        .b_reset   (b_reset),
        .clk_out   (sys_clk),
        .rise      (sys_clk_rise),
        .fall_next (sys_fall_next)
    );

    clk_div #(
        .DIV   (RTC_DIV),
        .CNT_W (CNT_W)
    ) u_rtc_div (
        .clk_in    (clk_in),
        .b_reset   (b_reset),
        .clk_out   (rtc_clk),
        .rise      (rtc_tick),
        .fall_next (rtc_fall_unused)
    );

    // Assertion is asynchronous through b_reset; release ripples through two flops.
    logic [1:0] sync_reg;
    logic       rst_sync;

    always_ff @(posedge clk_in or negedge b_reset) begin
        if (!b_reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[0], 1'b1};
        end
    end

    assign rst_sync = sync_reg[1];

    seq_state_t            state_reg;
    logic [RCNT_W-1:0]     rcnt_reg;
    logic                  sys_res_reg;
    logic                  sys_irq_reg;
    logic [IRQ_MISS_W-1:0] irq_miss_reg;

    always_ff @(posedge clk_in or negedge b_reset) begin
        if (!b_reset) begin
            state_reg    <= HOLD;
            rcnt_reg     <= '0;
            sys_res_reg  <= 1'b1;
            sys_irq_reg  <= 1'b0;
            irq_miss_reg <= '0;
        end else begin
            case (state_reg)
                HOLD: begin
                    if (rst_sync) begin
                        state_reg <= COUNT;
                        rcnt_reg  <= RES_INIT;
                    end
                end
                COUNT: begin
                    // Release only on a sys_clk falling edge so the CPU sees a settled reset.
                    if (rcnt_reg == '0) begin
                        if (sys_fall_next) begin
                            state_reg   <= RUN;
                            sys_res_reg <= 1'b0;
                        end
                    end else if (sys_clk_rise) begin
                        rcnt_reg <= rcnt_reg - RCNT_W'(1);
                    end
                end
                RUN: begin
                    if (rtc_tick) begin
                        sys_irq_reg <= 1'b1;
                        // An ack presented alongside the tick counts as the CPU keeping up.
                        if (sys_irq_reg && !irq_ack && irq_miss_reg != IRQ_MISS_MAX) begin
                            irq_miss_reg <= irq_miss_reg + IRQ_MISS_W'(1);
                        end
                    end else if (sys_clk_rise && irq_ack) begin
                        sys_irq_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= HOLD;
                    sys_res_reg <= 1'b1;
                end
            endcase
        end
    end

    assign sys_res  = sys_res_reg;
    assign sys_irq  = sys_irq_reg;
    assign irq_miss = irq_miss_reg;

    // Digits alternate every oscillator cycle during the low half of the RTC wave.
    logic led_h_reg;

    always_ff @(posedge clk_in or negedge b_reset) begin
        if (!b_reset) begin
            led_h_reg <= 1'b0;
        end else if (!rtc_clk) begin
            led_h_reg <= ~led_h_reg;
        end
    end

    assign led_pow_h = led_h_reg;
    assign led_pow_l = ~led_h_reg;

endmodule

// File: tb/tb_clk_rst_gen.sv
// Directed bench for clk_rst_gen with CLK_DIV=2, RTC_DIV=12, RES_CYCLES=4.
module tb_clk_rst_gen;

    logic       clk_in  = 1'b0;
    logic       b_reset = 1'b0;
    logic       irq_ack = 1'b0;
    logic       sys_clk, sys_clk_rise, sys_res, rtc_clk, rtc_tick, sys_irq;
    logic       led_pow_h, led_pow_l;
    logic [7:0] irq_miss;

    int   checks   = 0;
    int   failures = 0;
    int   n        = 0;
    logic exp_led  = 1'b0;
    logic exp_led_l;

    always #5 clk_in = ~clk_in;

    clk_rst_gen #(
        .OSC_CLOCK  (1200),
        .CPU_CLOCK  (300),
        .RTC_CLOCK  (50),
        .RES_CYCLES (4),
        .CNT_W      (25)
    ) dut (
        .clk_in       (clk_in),
        .b_reset      (b_reset),
        .irq_ack      (irq_ack),
        .sys_clk      (sys_clk),
        .sys_clk_rise (sys_clk_rise),
        .sys_res      (sys_res),
        .rtc_clk      (rtc_clk),
        .rtc_tick     (rtc_tick),
        .sys_irq      (sys_irq),
        .irq_miss     (irq_miss),
        .led_pow_h    (led_pow_h),
        .led_pow_l    (led_pow_l)
    );

    // Expected waveforms, n = clk_in rising edges since b_reset release.
    function automatic logic exp_sys_clk(input int c);
        return (c % 4) >= 2;
    endfunction
    function automatic logic exp_sys_rise(input int c);
        return (c % 4) == 2;
    endfunction
    function automatic logic exp_rtc(input int c);
        return ((c / 12) % 2) == 1;
    endfunction
    function automatic logic exp_rtc_tick(input int c);
        return (c % 24) == 12;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s n=%0d observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk_in);
            #1;
            n++;
        end
    endtask

    initial begin
        // Reset held with the oscillator running.
        step(5);
        check("rst_sys_clk", {7'd0, sys_clk}, 8'd0);
        check("rst_sys_rise", {7'd0, sys_clk_rise}, 8'd0);
        check("rst_sys_res", {7'd0, sys_res}, 8'd1);
        check("rst_rtc_clk", {7'd0, rtc_clk}, 8'd0);
        check("rst_rtc_tick", {7'd0, rtc_tick}, 8'd0);
        check("rst_sys_irq", {7'd0, sys_irq}, 8'd0);
        check("rst_irq_miss", irq_miss, 8'd0);
        check("rst_led_h", {7'd0, led_pow_h}, 8'd0);
        check("rst_led_l", {7'd0, led_pow_l}, 8'd1);

        // Release and follow the first 40 cycles edge by edge.
        b_reset = 1'b1;
        n       = 0;
        exp_led = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (!exp_rtc(n - 1)) exp_led = ~exp_led;
            exp_led_l = ~exp_led;
            check("sys_clk", {7'd0, sys_clk}, {7'd0, exp_sys_clk(n)});
            check("sys_clk_rise", {7'd0, sys_clk_rise}, {7'd0, exp_sys_rise(n)});
            check("rtc_clk", {7'd0, rtc_clk}, {7'd0, exp_rtc(n)});
            check("rtc_tick", {7'd0, rtc_tick}, {7'd0, exp_rtc_tick(n)});
            check("sys_res", {7'd0, sys_res}, (n < 20) ? 8'd1 : 8'd0);
            check("sys_irq_first", {7'd0, sys_irq}, (n >= 37) ? 8'd1 : 8'd0);
            check("led_h", {7'd0, led_pow_h}, {7'd0, exp_led});
            check("led_l", {7'd0, led_pow_l}, {7'd0, exp_led_l});
        end

        // Ack held for one sys_clk period; clears after the rise at n=42.
        irq_ack = 1'b1;
        step(2);
        check("irq_before_ack_rise", {7'd0, sys_irq}, 8'd1);
        step(1);
        check("irq_cleared", {7'd0, sys_irq}, 8'd0);
        step(1);
        irq_ack = 1'b0;
        check("irq_stays_clear", {7'd0, sys_irq}, 8'd0);
        check("miss_after_ack", irq_miss, 8'd0);

        step(16);
        check("tick_n60", {7'd0, rtc_tick}, 8'd1);
        check("irq_n60", {7'd0, sys_irq}, 8'd0);
        step(1);
        check("irq_n61", {7'd0, sys_irq}, 8'd1);
        check("miss_n61", irq_miss, 8'd0);

        // Ack coincident with a tick: interrupt stays, no miss recorded.
        step(23);
        check("tick_n84", {7'd0, rtc_tick}, 8'd1);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        check("irq_tick_ack", {7'd0, sys_irq}, 8'd1);
        check("miss_tick_ack", irq_miss, 8'd0);

        step(24);
        check("miss_first", irq_miss, 8'd1);
        step(144);
        check("miss_seven", irq_miss, 8'd7);
        step(1);
        check("pre_rst_sys_clk", {7'd0, sys_clk}, 8'd1);
        check("pre_rst_irq", {7'd0, sys_irq}, 8'd1);
        check("pre_rst_sys_res", {7'd0, sys_res}, 8'd0);

        // Mid-run reset must act without waiting for a clock edge.
        b_reset = 1'b0;
        #2;
        check("mid_rst_sys_res", {7'd0, sys_res}, 8'd1);
        check("mid_rst_irq", {7'd0, sys_irq}, 8'd0);
        check("mid_rst_miss", irq_miss, 8'd0);
        check("mid_rst_sys_clk", {7'd0, sys_clk}, 8'd0);
        check("mid_rst_rtc_clk", {7'd0, rtc_clk}, 8'd0);
        check("mid_rst_led_h", {7'd0, led_pow_h}, 8'd0);
        check("mid_rst_led_l", {7'd0, led_pow_l}, 8'd1);
        step(3);
        check("held_sys_clk", {7'd0, sys_clk}, 8'd0);
        check("held_sys_res", {7'd0, sys_res}, 8'd1);

        // Run without acks until the miss counter saturates.
        b_reset = 1'b1;
        n       = 0;
        step(20);
        check("rerun_sys_res", {7'd0, sys_res}, 8'd0);
        step(6113);
        check("miss_254", irq_miss, 8'd254);
        check("irq_254", {7'd0, sys_irq}, 8'd1);
        step(24);
        check("miss_255", irq_miss, 8'd255);
        step(1104);
        check("miss_saturated", irq_miss, 8'd255);
        check("irq_saturated", {7'd0, sys_irq}, 8'd1);
        exp_led_l = ~led_pow_h;
        check("led_complement", {7'd0, led_pow_l}, {7'd0, exp_led_l});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
